// File: rtl/risc_panel_pkg.sv
// risc_panel_pkg: shared FSM state type and bus widths for the front-panel memory writer
package risc_panel_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, REQ, HOLDOFF} state_t;
endpackage

// File: rtl/panel_mem_writer_if.sv
// panel_mem_writer_if: write-request bus between the panel writer and the memory unit
interface panel_mem_writer_if;
  import risc_panel_pkg::*;
  logic req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic ack;
  modport master(output req, addr, wdata, input ack);
  modport slave(input req, addr, wdata, output ack);
endinterface

// File: rtl/panel_debounce.sv
// panel_debounce: two-flop synchronizer plus debounce counter emitting one pulse per accepted press
module panel_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [1:0] sync;
  logic armed;
  logic [CW-1:0] cnt;
  logic done;
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  // armed waits for a stable 1 (fires), disarmed waits for a stable 0 (re-arms)
  always_ff @(posedge clk_i)
    if (rst) begin
      sync <= '0;
      armed <= 1'b1;
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      pulse <= armed & sync[1] & done;
      cnt <= (sync[1] == armed && !done) ? cnt + 1'b1 : '0;
      if (sync[1] == armed && done) armed <= ~armed;
    end
endmodule

// File: rtl/panel_mem_writer.sv
// panel_mem_writer: front-panel switch/button writer into memory; PANEL_AUTOINC_EN enables address auto-increment
module panel_mem_writer import risc_panel_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst,
  input  logic [DATA_W-1:0] sw_data,
  input  logic btn_addr,
  input  logic btn_write,
  input  logic btn_run,
  panel_mem_writer_if.master mem,
  output logic cpu_hold,
  output logic [7:0] wr_count,
  output logic err
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  state_t state, state_n;
  logic ev_addr, ev_write, ev_run;
  logic [DATA_W-1:0] sw_s1, sw_s2;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TW-1:0] tmo;
  logic tmo_done;
  logic hold_want;
  assign tmo_done = tmo == TW'(ACK_TIMEOUT - 1);
  panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_addr (.clk_i(clk_i), .rst(rst), .btn(btn_addr), .pulse(ev_addr));
  panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_write (.clk_i(clk_i), .rst(rst), .btn(btn_write), .pulse(ev_write));
  panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (.clk_i(clk_i), .rst(rst), .btn(btn_run), .pulse(ev_run));
  // state register
  always_ff @(posedge clk_i)
    state <= rst ? IDLE : state_n;
  // next state: write starts a request, ack or timeout ends it, holdoff is a single gap cycle
  always_comb
    state_n = (state == IDLE && ev_write) ? REQ :
              (state == REQ && (mem.ack || tmo_done)) ? HOLDOFF :
              (state == HOLDOFF) ? IDLE : state;
  // bus outputs: request is high exactly while in REQ, address/data come straight from registers
  always_comb begin
    mem.req = state == REQ;
    mem.addr = addr_q;
    mem.wdata = wdata_q;
  end
  // datapath: switch sync, address/data capture, ack timeout, counters, and deferred hold release
  always_ff @(posedge clk_i)
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      tmo <= '0;
      wr_count <= '0;
      err <= 1'b0;
      hold_want <= 1'b1;
      cpu_hold <= 1'b1;
    end else begin
      sw_s1 <= sw_data;
      sw_s2 <= sw_s1;
      tmo <= state == REQ ? tmo + 1'b1 : '0;
      if (state == IDLE && ev_addr) addr_q <= sw_s2[ADDR_W-1:0];
      if (state == IDLE && ev_write) wdata_q <= sw_s2;
      if (state == REQ && mem.ack) begin
        wr_count <= wr_count + 1'b1;
`ifdef PANEL_AUTOINC_EN
        addr_q <= addr_q + 1'b1;
`else
        addr_q <= addr_q;
`endif
      end
      if (state == REQ && !mem.ack && tmo_done) err <= 1'b1;
      hold_want <= hold_want ^ ev_run;
      cpu_hold <= (hold_want ^ ev_run) | (cpu_hold & (state_n != IDLE));
    end
endmodule

// File: doc/panel_mem_writer.md
PANEL_MEM_WRITER -- requirements
Module: panel_mem_writer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000: stable-input cycles before a button press is accepted (10 ms at 100 MHz).
REQ-002 Parameter ACK_TIMEOUT, default 255: maximum cycles to wait for mem_ack before aborting a write.
REQ-003 clk_i  input  1  system clock, 100 MHz; the only clock in the block.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sw_data  input  16  board switch value, asynchronous to clk_i.
REQ-006 btn_addr  input  1  raw pushbutton; on press, sw_data[7:0] is latched as the write address.
REQ-007 btn_write  input  1  raw pushbutton; on press, sw_data is written to the latched address.
REQ-008 btn_run  input  1  raw pushbutton; on press, cpu_hold toggles.
REQ-009 mem_req  output  1  write request to the memory unit.
REQ-010 mem_addr  output  8  write address; stable while mem_req=1.
REQ-011 mem_wdata  output  16  write data; stable while mem_req=1.
REQ-012 mem_ack  input  1  single-cycle write-complete pulse from the memory unit.
REQ-013 cpu_hold  output  1  holds the RISC machine in reset while 1.
REQ-014 wr_count  output  8  count of completed writes, wrapping at 255->0.
REQ-015 err  output  1  sticky flag for an ack timeout.

Function
REQ-016 Each button and sw_data pass through a two-flop synchronizer before any other use.
- A button event is a single-cycle pulse.
- The pulse fires once the synchronized level has been 1 for DEBOUNCE_CYCLES consecutive cycles, then re-arms only after the level has been 0 for DEBOUNCE_CYCLES.
REQ-017 FSM states are IDLE, REQ and HOLDOFF.
REQ-018 IDLE, addr event: the address register loads sync sw_data[7:0]; the FSM stays in IDLE.
REQ-019 IDLE, write event: mem_wdata captures sync sw_data, mem_req goes to 1 on the next cycle, and the FSM enters REQ.
REQ-020 REQ: mem_addr and mem_wdata hold constant.
- mem_ack=1: mem_req drops on the next cycle, wr_count increments, and the FSM enters HOLDOFF.
- ACK_TIMEOUT cycles without mem_ack: mem_req drops, err sets, wr_count is unchanged, and the FSM enters HOLDOFF.
REQ-021 HOLDOFF lasts exactly 1 cycle, then the FSM returns to IDLE; this guarantees mem_req is low for at least 1 cycle between requests.
REQ-022 Addr or write events arriving in REQ or HOLDOFF are dropped, not queued.
REQ-023 Simultaneous addr and write events in IDLE: the address loads first, and the write uses the newly loaded address.
REQ-024 A run event toggles cpu_hold in any state.
- The toggle to 0 is deferred while the FSM is not in IDLE.
- It takes effect on the first IDLE cycle.
REQ-025 mem_ack while not in REQ is ignored.
REQ-026 err clears only on rst.

Reset
REQ-027 On rst=1 at a clk_i edge, the following apply:
- FSM returns to IDLE.
- mem_req=0, mem_addr=0, mem_wdata=0, wr_count=0, err=0, cpu_hold=1.
- Debounce counters clear; synchronizers clear to 0.
REQ-028 Reset during REQ drops mem_req on the next cycle; the pending write is abandoned and not counted.

Configuration
REQ-029 Macro PANEL_AUTOINC_EN controls address auto-increment.
- Defined: each acked write increments the address register by 1, wrapping 255->0, in the same cycle wr_count increments.
- Undefined: the address register changes only on an addr event or rst.

Structure
REQ-030 Shared package risc_panel_pkg holds the following:
- FSM state typedef.
- ADDR_W=8 and DATA_W=16 constants.
REQ-031 A single sub-module, panel_debounce, is instantiated three times, once per button; it contains the synchronizer, the counter and the pulse generator.

Verification
REQ-032 Reset release: cpu_hold=1, mem_req=0, wr_count=0, err=0.
REQ-033 With DEBOUNCE_CYCLES=4, sw_data=0x00C9 and an addr press, then sw_data=0xBEEF and a write press, with mem_ack 3 cycles after mem_req: exactly one request with mem_addr=0xC9, mem_wdata=0xBEEF; wr_count=1.
REQ-034 btn_write pulse shorter than DEBOUNCE_CYCLES, or bouncing 1/0 every 2 cycles: no mem_req.
REQ-035 mem_ack never asserted: mem_req falls after 255 cycles, err=1, wr_count unchanged; a later acked write still completes.
REQ-036 PANEL_AUTOINC_EN defined, address 0xFF, two acked writes: second mem_addr=0x00; wr_count=2.
REQ-037 Run press during REQ: cpu_hold stays 1 until the FSM reaches IDLE, then reads 0; a second run press returns it to 1.
